stash_access_sequencer: RTL and testbench

- Top-level access controller for the parametrised Path ORAM stash.
- Sequences one ORAM access through a stash core and scan table: scan, path read, block return to LLC, LLC eviction, rescan, path writeback.
- Adds three things the previous generation lacked: dummy-access bypass, return/evict phases, and a live occupancy counter with almost-full and overflow status.

---
 rtl/stash_access_sequencer_pkg.sv | 37 +++
 rtl/stash_access_sequencer_if.sv | 37 +++
 rtl/stash_access_sequencer_occupancy_counter.sv | 60 ++++++
 rtl/stash_access_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_stash_access_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stash_access_sequencer_pkg.sv
// Shared types and width helpers for the stash access sequencer.
package stash_access_sequencer_pkg;

    localparam int unsigned CMDWidth = 2;

    // Stash core command encoding.
    typedef enum logic [CMDWidth-1:0] {
        CMD_Push = 2'd0,
        CMD_Peak = 2'd1,
        CMD_Dump = 2'd2,
        CMD_Pop  = 2'd3
    } coreCmd_t;

    // Access sequencer states.
    typedef enum logic [3:0] {
        StReset     = 4'd0,
        StIdle      = 4'd1,
        StScan1     = 4'd2,
        StPathRead  = 4'd3,
        StScan2     = 4'd4,
        StReturn    = 4'd5,
        StEvict     = 4'd6,
        StRescan    = 4'd7,
        StWriteback = 4'd8
    } seqState_t;

    // Width needed to count 0..BlocksOnPath inclusive.
    function automatic int unsigned bpWidthOf(input int unsigned oramL, input int unsigned oramZ);
        return $clog2(oramZ * (oramL + 1) + 1);
    endfunction

    // Width needed to count 0..capacity inclusive.
    function automatic int unsigned occWidthOf(input int unsigned capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/stash_access_sequencer_if.sv
// Handshake bundle between the access sequencer and the stash core, LLC and
// encrypt/decrypt datapath. The master side is the sequencer.
interface stash_access_sequencer_if #(
    parameter int unsigned BPWidth = 8
);
    import stash_access_sequencer_pkg::*;

    coreCmd_t           CoreCommand;
    logic               CoreCommandValid;
    logic               CoreCommandReady;
    logic               ScanHit;
    logic               CoreOutValid;
    logic               CoreOutIsReal;
    logic               ReturnOutValid;
    logic               ReturnMiss;
    logic               ReturnOutReady;
    logic               EvictInValid;
    logic               EvictInReady;
    logic [BPWidth-1:0] WritebackSlot;
    logic               ReadOutValid;
    logic               ReadOutReady;

    modport master (
        output CoreCommand, CoreCommandValid, ReturnOutValid, ReturnMiss,
        output EvictInReady, WritebackSlot, ReadOutValid,
        input  CoreCommandReady, ScanHit, CoreOutValid, CoreOutIsReal,
        input  ReturnOutReady, EvictInValid, ReadOutReady
    );

    modport slave (
        input  CoreCommand, CoreCommandValid, ReturnOutValid, ReturnMiss,
        input  EvictInReady, WritebackSlot, ReadOutValid,
        output CoreCommandReady, ScanHit, CoreOutValid, CoreOutIsReal,
        output ReturnOutReady, EvictInValid, ReadOutReady
    );

endinterface

// File: rtl/stash_access_sequencer_occupancy_counter.sv
// Saturating up/down count of real blocks held in the stash, with an
// almost-full level and a sticky overflow flag.
module stash_occupancy_counter
    import stash_access_sequencer_pkg::*;
#(
    parameter int unsigned  Capacity = 100,
    parameter int unsigned  Margin   = 8,
    localparam int unsigned OccWidth = occWidthOf(Capacity)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Increment,
    input  logic                Decrement,
    output logic [OccWidth-1:0] Occupancy,
    output logic                AlmostFull,
    output logic                Overflow
);

    // Signed so a zero level does not make the compare trivially constant.
    localparam int AlmostFullLevel = (Margin >= Capacity) ? 0 : int'(Capacity - Margin);

    logic [OccWidth-1:0] countQ, countD;
    logic                overflowQ, overflowD;

    // Next count: hold at the rails, flag an increment that would exceed capacity.
    always_comb begin
        countD    = countQ;
        overflowD = overflowQ;
        if (Increment && !Decrement) begin
            if (countQ == OccWidth'(Capacity)) begin
                overflowD = 1'b1;
            end else begin
                countD = countQ + OccWidth'(1);
            end
        end else if (Decrement && !Increment) begin
            if (countQ != '0) begin
                countD = countQ - OccWidth'(1);
            end
        end
    end

    // Count and sticky overflow registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            countQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            countQ    <= countD;
            overflowQ <= overflowD;
        end
    end

    // Status outputs.
    always_comb begin
        Occupancy  = countQ;
        Overflow   = overflowQ;
        AlmostFull = (int'(countQ) >= AlmostFullLevel);
    end

endmodule

// File: rtl/stash_access_sequencer.sv
// Sequences one Path ORAM access through the stash core: scan, path read,
// rescan, return to LLC, LLC eviction, rescan and path writeback. Dummy
// accesses skip return and eviction.
module stash_access_sequencer
    import stash_access_sequencer_pkg::*;
#(
    parameter int unsigned  ORAML            = 32,
    parameter int unsigned  ORAMZ            = 4,
    parameter int unsigned  StashCapacity    = 100,
    parameter int unsigned  AlmostFullMargin = 8,
    parameter int unsigned  ScanDelay        = 6,
    localparam int unsigned BlocksOnPath     = ORAMZ * (ORAML + 1),
    localparam int unsigned BPWidth          = bpWidthOf(ORAML, ORAMZ),
    localparam int unsigned OccWidth         = occWidthOf(StashCapacity)
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          CoreResetDone,
    input  logic                          AccessIsDummy,
    input  logic                          StartScanOperation,
    input  logic                          StartReadOperation,
    input  logic                          WriteInValid,
    input  logic                          WriteIsReal,
    stash_access_sequencer_if.master      Bus,
    output logic [OccWidth-1:0]           Occupancy,
    output logic                          StashAlmostFull,
    output logic                          StashOverflow
);

    localparam int unsigned DelayWidth = $clog2(ScanDelay + 1);

    seqState_t             stateQ, stateD;
    logic                  isDummyQ, isDummyD;
    logic                  hitQ, hitD;
    logic                  dumpDoneQ, dumpDoneD;    // scan Dump accepted, delay running
    logic [DelayWidth-1:0] delayQ, delayD;
    logic                  popDoneQ, popDoneD;      // hit Pop accepted, block on offer
    logic [BPWidth-1:0]    slotQ, slotD;
    logic                  occInc, occDec;

    // Next-state and output decode for the access sequence.
    always_comb begin
        stateD               = stateQ;
        isDummyD             = isDummyQ;
        hitD                 = hitQ;
        dumpDoneD            = dumpDoneQ;
        delayD               = delayQ;
        popDoneD             = popDoneQ;
        slotD                = slotQ;
        occInc               = 1'b0;
        occDec               = 1'b0;
        Bus.CoreCommand      = CMD_Push;
        Bus.CoreCommandValid = 1'b0;
        Bus.ReturnOutValid   = 1'b0;
        Bus.ReturnMiss       = 1'b0;
        Bus.EvictInReady     = 1'b0;
        Bus.ReadOutValid     = 1'b0;

        unique case (stateQ)
            StReset: begin
                if (CoreResetDone) stateD = StIdle;
            end
            StIdle: begin
                if (StartScanOperation) begin
                    stateD   = StScan1;
                    isDummyD = AccessIsDummy;
                end else if (WriteInValid) begin
                    stateD = StPathRead;
                end
            end
            StScan1: begin
                Bus.CoreCommand      = CMD_Dump;
                Bus.CoreCommandValid = 1'b1;
                if (WriteInValid) begin
                    stateD = StPathRead;
                end else if (Bus.CoreCommandReady) begin
                    stateD = StIdle;
                end
            end
            StPathRead: begin
                Bus.CoreCommand      = CMD_Push;
                Bus.CoreCommandValid = WriteInValid;
                occInc               = WriteInValid && Bus.CoreCommandReady && WriteIsReal;
                if (StartReadOperation) stateD = StScan2;
            end
            StScan2, StRescan: begin
                if (!dumpDoneQ) begin
                    Bus.CoreCommand      = CMD_Dump;
                    Bus.CoreCommandValid = 1'b1;
                    if (Bus.CoreCommandReady) dumpDoneD = 1'b1;
                end else if (delayQ == DelayWidth'(ScanDelay - 1)) begin
                    dumpDoneD = 1'b0;
                    delayD    = '0;
                    hitD      = Bus.ScanHit;
                    stateD    = (stateQ == StRescan || isDummyQ) ? StWriteback : StReturn;
                end else begin
                    delayD = delayQ + DelayWidth'(1);
                end
            end
            StReturn: begin
                if (hitQ) begin
                    if (!popDoneQ) begin
                        Bus.CoreCommand      = CMD_Pop;
                        Bus.CoreCommandValid = 1'b1;
                        if (Bus.CoreCommandReady) begin
                            popDoneD = 1'b1;
                            occDec   = 1'b1;
                        end
                    end else begin
                        Bus.ReturnOutValid = 1'b1;
                        if (Bus.ReturnOutReady) begin
                            popDoneD = 1'b0;
                            stateD   = StEvict;
                        end
                    end
                end else begin
                    Bus.ReturnOutValid = 1'b1;
                    Bus.ReturnMiss     = 1'b1;
                    if (Bus.ReturnOutReady) stateD = StEvict;
                end
            end
            StEvict: begin
                Bus.CoreCommand      = CMD_Push;
                Bus.CoreCommandValid = Bus.EvictInValid;
                Bus.EvictInReady     = Bus.CoreCommandReady;
                if (Bus.EvictInValid && Bus.CoreCommandReady) begin
                    occInc = 1'b1;
                    stateD = StRescan;
                end
            end
            StWriteback: begin
                if (slotQ == BPWidth'(BlocksOnPath)) begin
                    slotD  = '0;
                    stateD = StIdle;
                end else begin
                    Bus.CoreCommand      = CMD_Peak;
                    Bus.CoreCommandValid = 1'b1;
                    Bus.ReadOutValid     = Bus.CoreOutValid;
                    if (Bus.CoreCommandReady && Bus.ReadOutReady) begin
                        slotD  = slotQ + BPWidth'(1);
                        occDec = Bus.CoreOutIsReal;
                    end
                end
            end
            default: stateD = StReset;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ    <= StReset;
            isDummyQ  <= 1'b0;
            hitQ      <= 1'b0;
            dumpDoneQ <= 1'b0;
            delayQ    <= '0;
            popDoneQ  <= 1'b0;
            slotQ     <= '0;
        end else begin
            stateQ    <= stateD;
            isDummyQ  <= isDummyD;
            hitQ      <= hitD;
            dumpDoneQ <= dumpDoneD;
            delayQ    <= delayD;
            popDoneQ  <= popDoneD;
            slotQ     <= slotD;
        end
    end

    // Writeback address is the slot counter, zero outside writeback.
    always_comb begin
        Bus.WritebackSlot = slotQ;
    end

    stash_occupancy_counter #(
        .Capacity (StashCapacity),
        .Margin   (AlmostFullMargin)
    ) u_occupancy (
        .Clock      (Clock),
        .Reset      (Reset),
        .Increment  (occInc),
        .Decrement  (occDec),
        .Occupancy  (Occupancy),
        .AlmostFull (StashAlmostFull),
        .Overflow   (StashOverflow)
    );

endmodule

// File: tb/tb_stash_access_sequencer.sv
// Directed bench for stash_access_sequencer: ORAML=3, ORAMZ=4 (16 blocks per
// path), capacity 8, margin 8, scan delay 6. Inputs change 1 time unit after
// the rising edge; everything is sampled on the falling edge.
module tb_stash_access_sequencer;
    import stash_access_sequencer_pkg::*;

    localparam int unsigned BPW  = 5;
    localparam int unsigned OccW = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic CoreResetDone = 1'b0;
    logic AccessIsDummy = 1'b0;
    logic StartScanOperation = 1'b0;
    logic StartReadOperation = 1'b0;
    logic WriteInValid = 1'b0;
    logic WriteIsReal = 1'b0;
    logic [OccW-1:0] Occupancy;
    logic StashAlmostFull;
    logic StashOverflow;

    stash_access_sequencer_if #(.BPWidth(BPW)) bus ();

    stash_access_sequencer #(
        .ORAML            (3),
        .ORAMZ            (4),
        .StashCapacity    (8),
        .AlmostFullMargin (8),
        .ScanDelay        (6)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .CoreResetDone      (CoreResetDone),
        .AccessIsDummy      (AccessIsDummy),
        .StartScanOperation (StartScanOperation),
        .StartReadOperation (StartReadOperation),
        .WriteInValid       (WriteInValid),
        .WriteIsReal        (WriteIsReal),
        .Bus                (bus),
        .Occupancy          (Occupancy),
        .StashAlmostFull    (StashAlmostFull),
        .StashOverflow      (StashOverflow)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int passes = 0;
    int popCount = 0;
    int retValidSeen = 0;
    int evictReadySeen = 0;
    bit retQ[$];
    int slotQ[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT completes a
    // return or a writeback beat.
    always @(negedge Clock) begin
        if (bus.ReturnOutValid) retValidSeen++;
        if (bus.EvictInReady) evictReadySeen++;
        if (bus.CoreCommandValid && bus.CoreCommandReady && bus.CoreCommand == CMD_Pop) popCount++;
        if (bus.ReturnOutValid && bus.ReturnOutReady) begin
            if (retQ.size() == 0) begin
                checks++;
                $display("FAIL return_unexpected: got a returned block, expected none");
            end else begin
                check("return_miss", int'(bus.ReturnMiss), int'(retQ.pop_front()));
            end
        end
        if (bus.ReadOutValid && bus.ReadOutReady && bus.CoreCommandReady) begin
            if (slotQ.size() == 0) begin
                checks++;
                $display("FAIL wb_unexpected: got slot %0d, expected no beat", bus.WritebackSlot);
            end else begin
                check("wb_slot", int'(bus.WritebackSlot), slotQ.pop_front());
            end
        end
    end

    // Outputs that must be quiet in Reset/Idle; almost-full is 1 at any
    // occupancy because the level is 8-8=0.
    task automatic check_quiet(input string tag);
        check({tag, "_cmd_valid"}, int'(bus.CoreCommandValid), 0);
        check({tag, "_ret_valid"}, int'(bus.ReturnOutValid), 0);
        check({tag, "_evict_ready"}, int'(bus.EvictInReady), 0);
        check({tag, "_read_valid"}, int'(bus.ReadOutValid), 0);
        check({tag, "_slot"}, int'(bus.WritebackSlot), 0);
        check({tag, "_occ"}, int'(Occupancy), 0);
        check({tag, "_overflow"}, int'(StashOverflow), 0);
        check({tag, "_almost_full"}, int'(StashAlmostFull), 1);
    endtask

    task automatic start_access(input logic dummy, input logic hit);
        AccessIsDummy = dummy;
        bus.ScanHit = hit;
        StartScanOperation = 1'b1;
        tick();
        StartScanOperation = 1'b0;
    endtask

    // Offer 16 path blocks; bit i of realMask marks block i real.
    task automatic push_path(input logic [15:0] realMask);
        int i = 0;
        int guard = 0;
        while (i < 16 && guard < 100) begin
            WriteInValid = 1'b1;
            WriteIsReal = realMask[i];
            @(negedge Clock);
            if (bus.CoreCommandValid && bus.CoreCommandReady && bus.CoreCommand == CMD_Push) i++;
            tick();
            guard++;
        end
        WriteInValid = 1'b0;
        WriteIsReal = 1'b0;
        check("push_count", i, 16);
        StartReadOperation = 1'b1;
        tick();
        StartReadOperation = 1'b0;
    endtask

    task automatic do_return(input bit expMiss, input int holdCycles);
        int guard = 0;
        retQ.push_back(expMiss);
        bus.ReturnOutReady = 1'b0;
        @(negedge Clock);
        while (!bus.ReturnOutValid && guard < 60) begin
            @(negedge Clock);
            guard++;
        end
        check("return_valid_seen", int'(bus.ReturnOutValid), 1);
        for (int k = 0; k < holdCycles; k++) begin
            @(negedge Clock);
            check("return_held", int'(bus.ReturnOutValid), 1);
        end
        tick();
        bus.ReturnOutReady = 1'b1;
        tick();
        bus.ReturnOutReady = 1'b0;
    endtask

    task automatic do_evict();
        int guard = 0;
        bit done = 1'b0;
        bus.EvictInValid = 1'b1;
        while (!done && guard < 60) begin
            @(negedge Clock);
            if (bus.EvictInReady && bus.EvictInValid) done = 1'b1;
            tick();
            guard++;
        end
        bus.EvictInValid = 1'b0;
        check("evict_accepted", int'(done), 1);
    endtask

    // Drain 16 writeback beats; bit n of realMask marks beat n real.
    task automatic do_writeback(input logic [15:0] realMask, input bit toggle);
        int n = 0;
        int guard = 0;
        bit stallPending = 1'b0;
        int stallSlot = 0;
        for (int s = 0; s < 16; s++) slotQ.push_back(s);
        bus.CoreOutValid = 1'b1;
        bus.ReadOutReady = toggle ? 1'b0 : 1'b1;
        while (n < 16 && guard < 200) begin
            bus.CoreOutIsReal = realMask[n];
            @(negedge Clock);
            if (stallPending) check("wb_stall_hold", int'(bus.WritebackSlot), stallSlot);
            stallPending = bus.ReadOutValid && !bus.ReadOutReady;
            stallSlot = int'(bus.WritebackSlot);
            if (bus.ReadOutValid && bus.ReadOutReady && bus.CoreCommandReady) n++;
            tick();
            guard++;
            if (toggle) bus.ReadOutReady = ~bus.ReadOutReady;
        end
        check("wb_advances", n, 16);
        bus.CoreOutIsReal = 1'b0;
        @(negedge Clock);
        check("wb_slot_end", int'(bus.WritebackSlot), 16);
        check("wb_valid_end", int'(bus.ReadOutValid), 0);
        tick();
        @(negedge Clock);
        check("wb_slot_clear", int'(bus.WritebackSlot), 0);
        tick();
        bus.CoreOutValid = 1'b0;
        bus.ReadOutReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary by the time limit, expected completion");
        $fatal(1);
    end

    initial begin
        int retBase;
        int evBase;
        int popBase;
        // Provoke outputs during reset; they must stay quiet.
        bus.CoreCommandReady = 1'b1;
        bus.ScanHit = 1'b0;
        bus.CoreOutValid = 1'b1;
        bus.CoreOutIsReal = 1'b1;
        bus.ReturnOutReady = 1'b1;
        bus.EvictInValid = 1'b1;
        bus.ReadOutReady = 1'b1;

        repeat (3) tick();
        Reset = 1'b0;
        @(negedge Clock);
        check_quiet("reset");
        tick();
        CoreResetDone = 1'b1;
        tick();
        bus.CoreOutValid = 1'b0;
        bus.CoreOutIsReal = 1'b0;
        bus.ReturnOutReady = 1'b0;
        bus.EvictInValid = 1'b0;
        bus.ReadOutReady = 1'b0;
        @(negedge Clock);
        check_quiet("idle");
        tick();

        // Dummy access: 5 real pushed, 3 real written back -> 2.
        retBase = retValidSeen;
        evBase = evictReadySeen;
        start_access(1'b1, 1'b1);
        push_path(16'h001F);
        check("dummy_occ_after_push", int'(Occupancy), 5);
        do_writeback(16'h0007, 1'b0);
        check("dummy_occ_after_wb", int'(Occupancy), 2);
        check("dummy_no_return", retValidSeen - retBase, 0);
        check("dummy_no_evict", evictReadySeen - evBase, 0);

        // Real access, hit: one Pop, return held 4 cycles, evict, toggled writeback.
        start_access(1'b0, 1'b1);
        push_path(16'h0000);
        check("hit_occ_after_push", int'(Occupancy), 2);
        popBase = popCount;
        do_return(1'b0, 4);
        check("hit_pop_count", popCount - popBase, 1);
        check("hit_occ_after_return", int'(Occupancy), 1);
        do_evict();
        check("hit_occ_after_evict", int'(Occupancy), 2);
        do_writeback(16'h0000, 1'b1);
        check("hit_pop_total", popCount - popBase, 1);
        check("hit_occ_after_wb", int'(Occupancy), 2);

        // Real access, miss: no Pop, evict adds one.
        start_access(1'b0, 1'b0);
        push_path(16'h0000);
        popBase = popCount;
        do_return(1'b1, 0);
        do_evict();
        check("miss_pop_count", popCount - popBase, 0);
        check("miss_occ_after_evict", int'(Occupancy), 3);
        do_writeback(16'h0000, 1'b0);
        check("miss_occ_after_wb", int'(Occupancy), 3);

        // Overflow: 3 + 9 real pushes saturates at 8.
        start_access(1'b1, 1'b0);
        push_path(16'h01FF);
        check("ovf_occ", int'(Occupancy), 8);
        check("ovf_flag", int'(StashOverflow), 1);
        check("ovf_almost_full", int'(StashAlmostFull), 1);
        do_writeback(16'h0000, 1'b0);
        check("ovf_occ_after_wb", int'(Occupancy), 8);
        check("ovf_sticky", int'(StashOverflow), 1);

        // Reset in the middle of a path read clears count and overflow.
        start_access(1'b0, 1'b1);
        WriteInValid = 1'b1;
        WriteIsReal = 1'b1;
        repeat (3) tick();
        check("midreset_occ_before", int'(Occupancy), 8);
        WriteInValid = 1'b0;
        WriteIsReal = 1'b0;
        Reset = 1'b1;
        CoreResetDone = 1'b0;
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        check_quiet("midreset");
        tick();
        CoreResetDone = 1'b1;
        tick();

        // Decrement at zero holds: 1 real pushed, 2 real written back -> 0.
        start_access(1'b1, 1'b0);
        push_path(16'h0001);
        check("floor_occ_after_push", int'(Occupancy), 1);
        do_writeback(16'h0003, 1'b0);
        check("floor_occ_after_wb", int'(Occupancy), 0);
        check("final_ret_queue_empty", retQ.size(), 0);
        check("final_slot_queue_empty", slotQ.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
